// File: rtl/flp_pkg.sv
// Shared constants and FSM state type for the integer to IEEE-754 single converter.
package flp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int INT_W    = 32;

  // Exponent of a value whose leading one sits at bit INT_W-1.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + INT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } flp_state_e;

endpackage

// File: rtl/flp_round.sv
// Round-to-nearest-even of a normalised 32-bit magnitude (mag_i[31] = 1) down to a 23-bit fraction.
module flp_round
  import flp_pkg::*;
(
  input  logic [INT_W-1:0]  mag_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [EXP_W-1:0]  exp_out_o,
  output logic [FRAC_W-1:0] frac_o
);

  logic [FRAC_W:0]   kept;
  logic              lsb;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [FRAC_W+1:0] sum;
  logic              carry;

  always_comb begin
    kept     = mag_i[INT_W-1 -: FRAC_W+1];
    lsb      = mag_i[8];
    guard    = mag_i[7];
    sticky   = |mag_i[6:0];
    round_up = guard & (sticky | lsb);
    sum      = {1'b0, kept} + {{(FRAC_W+1){1'b0}}, round_up};
    carry    = sum[FRAC_W+1];
    // On carry the sum is exactly 2^24, so sum[23:1] is the all-zero fraction.
    frac_o    = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    exp_out_o = exp_i + {{(EXP_W-1){1'b0}}, carry};
  end

endmodule

// File: rtl/int_to_flp.sv
// Multi-cycle integer to IEEE-754 single converter: shift-normalise one bit per cycle, then round.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid-side data is ignored otherwise.
module int_to_flp
  import flp_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] dout
);

  flp_state_e        state_q, state_d;
  logic [INT_W-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [INT_W-1:0]  dout_q, dout_d;
  logic [EXP_W-1:0]  rnd_exp;
  logic [FRAC_W-1:0] rnd_frac;
  logic              din_neg;

  flp_round u_round (
    .mag_i     (mag_q),
    .exp_i     (exp_q),
    .exp_out_o (rnd_exp),
    .frac_o    (rnd_frac)
  );

  assign din_neg = SIGNED_IN & din[INT_W-1];

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = din_neg;
          // Negating 0x80000000 wraps to itself, which is the correct magnitude.
          mag_d  = din_neg ? (~din + 1'b1) : din;
          exp_d  = EXP_INIT;
          if (din == '0) begin
            dout_d  = '0;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[INT_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[INT_W-2:0], 1'b0};
          exp_d = exp_q - 1'b1;
        end
      end
      ROUND: begin
        dout_d  = {sign_q, rnd_exp, rnd_frac};
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      dout_q  <= dout_d;
    end
  end

  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;

endmodule

// File: tb/tb_int_to_flp.sv
// Bench for int_to_flp: a signed and an unsigned instance, directed vector table, corner sequences, random vs. model.
module tb_int_to_flp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_din, s_dout;
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [31:0] u_din, u_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int_to_flp #(.SIGNED_IN(1'b1)) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .din       (s_din),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .dout      (s_dout)
  );

  int_to_flp #(.SIGNED_IN(1'b0)) u_dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (u_in_valid),
    .in_ready  (u_in_ready),
    .din       (u_din),
    .out_valid (u_out_valid),
    .out_ready (u_out_ready),
    .dout      (u_dout)
  );

  typedef struct {
    logic [31:0] din;
    bit          uns;
    logic [31:0] exp_dout;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact binary value, round half to even, latency = edges after acceptance until out_valid.
  function automatic logic [31:0] ref_flp(input logic [31:0] d, input bit uns, output int lat);
    bit               neg;
    longint unsigned  m, q, rem, half;
    int               p, sh, e;
    neg = !uns && d[31];
    m = neg ? (64'h1_0000_0000 - longint'(d)) : longint'(d);
    if (m == 0) begin
      lat = 0;
      return 32'h0;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    lat = (31 - p) + 2;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {neg, 8'(e), q[22:0]};
  endfunction

  function automatic logic get_in_ready(input bit uns);
    return uns ? u_in_ready : s_in_ready;
  endfunction
  function automatic logic get_out_valid(input bit uns);
    return uns ? u_out_valid : s_out_valid;
  endfunction
  function automatic logic [31:0] get_dout(input bit uns);
    return uns ? u_dout : s_dout;
  endfunction

  task automatic drive_in(input bit uns, input logic v, input logic [31:0] d);
    if (uns) begin u_in_valid = v; u_din = d; end
    else     begin s_in_valid = v; s_din = d; end
  endtask

  task automatic drive_out_ready(input bit uns, input logic r);
    if (uns) u_out_ready = r;
    else     s_out_ready = r;
  endtask

  // One full transaction; hold = cycles of out_ready low while in DONE.
  task automatic run_txn(input bit uns, input logic [31:0] d, input int hold,
                         output logic [31:0] res, output int lat);
    @(negedge clk);
    check("in_ready_idle", 32'(get_in_ready(uns)), 32'h1);
    drive_in(uns, 1'b1, d);
    @(posedge clk);
    #1;
    drive_in(uns, 1'b0, $urandom);
    lat = 0;
    while (!get_out_valid(uns) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) begin
      checks++;
      errors++;
      $display("FAIL timeout: no out_valid for din %h after %0d cycles", d, lat);
      res = 'x;
      return;
    end
    res = get_dout(uns);
    check("in_ready_done", 32'(get_in_ready(uns)), 32'h0);
    repeat (hold) begin
      drive_in(uns, 1'($urandom_range(0, 1)), $urandom);
      @(posedge clk);
      #1;
      check("hold_dout", get_dout(uns), res);
      check("hold_valid", 32'(get_out_valid(uns)), 32'h1);
    end
    drive_in(uns, 1'b0, 32'h0);
    drive_out_ready(uns, 1'b1);
    @(posedge clk);
    #1;
    drive_out_ready(uns, 1'b0);
    check("exit_valid", 32'(get_out_valid(uns)), 32'h0);
    check("exit_in_ready", 32'(get_in_ready(uns)), 32'h1);
    check("retain_dout", get_dout(uns), res);
  endtask

  initial begin
    logic [31:0] res, expd;
    int          lat, exp_lat, seen;
    bit          uns;
    logic [31:0] d;
    int          s;

    vecs[0]  = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 33};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b0, 32'hBF80_0000, 33};
    vecs[2]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 0};
    vecs[3]  = '{32'h7FFF_FFFF, 1'b0, 32'h4F00_0000, 3};
    vecs[4]  = '{32'h8000_0000, 1'b0, 32'hCF00_0000, 2};
    vecs[5]  = '{32'h8000_0000, 1'b1, 32'h4F00_0000, 2};
    vecs[6]  = '{32'd16777217,  1'b0, 32'h4B80_0000, 9};
    vecs[7]  = '{32'd16777219,  1'b0, 32'h4B80_0002, 9};
    vecs[8]  = '{32'h0000_0002, 1'b0, 32'h4000_0000, 32};
    vecs[9]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 0};
    vecs[10] = '{32'hFFFF_FFFF, 1'b1, 32'h4F80_0000, 2};

    rst_n = 1'b0;
    s_in_valid = 1'b0; s_din = '0; s_out_ready = 1'b0;
    u_in_valid = 1'b0; u_din = '0; u_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(s_in_ready), 32'h0);
    check("rst_out_valid", 32'(s_out_valid), 32'h0);
    check("rst_dout", s_dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(s_in_ready), 32'h1);
    check("post_rst_in_ready_u", 32'(u_in_ready), 32'h1);

    foreach (vecs[i]) begin
      run_txn(vecs[i].uns, vecs[i].din, 0, res, lat);
      check($sformatf("vec%0d_dout", i), res, vecs[i].exp_dout);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: five stalled cycles in DONE.
    run_txn(1'b0, 32'd12345, 5, res, lat);
    check("bp_dout", res, 32'h4640_E400);

    // Reset in the middle of NORM abandons the conversion.
    @(negedge clk);
    s_in_valid = 1'b1;
    s_din = 32'h1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(s_out_valid), 32'h0);
    check("midrst_dout", s_dout, 32'h0);
    check("midrst_in_ready", 32'(s_in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_release_in_ready", 32'(s_in_ready), 32'h1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (s_out_valid) seen++;
    end
    check("midrst_no_valid_pulse", 32'(seen), 32'h0);
    run_txn(1'b0, 32'h2, 0, res, lat);
    check("midrst_next_dout", res, 32'h4000_0000);

    // Randomized against the reference model.
    for (int n = 0; n < 300; n++) begin
      uns = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'($urandom_range(0, 2000)) - 32'd1000;
        2: d = $urandom >> $urandom_range(0, 31);
        default: begin
          s = $urandom_range(1, 7);
          d = ((32'h0080_0000 | ($urandom & 32'h007F_FFFF)) << s) | (32'h1 << (s - 1));
        end
      endcase
      expd = ref_flp(d, uns, exp_lat);
      run_txn(uns, d, $urandom_range(0, 3), res, lat);
      check($sformatf("rand%0d_dout_%h", n, d), res, expd);
      check($sformatf("rand%0d_lat_%h", n, d), 32'(lat), 32'(exp_lat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
